muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit. It sits beside the combinational alu in the execute stage.
- It takes the same operand pair (in_a, in_b) plus an M-extension op code, and computes the result over multiple cycles.
- It uses valid/ready handshakes on both sides, so the pipeline control can stall around it.
- It implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.

---
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle over operand magnitudes, with valid/ready handshakes on both sides.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op_code,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIX,
        SPECIAL,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [2:0]       op_q;
    logic             sign_a_q, sign_b_q;
    logic             special_q;
    logic [XLEN-1:0]  special_val_q;
    logic [XLEN-1:0]  mcand_q;
    logic [XLEN-1:0]  acc_hi_q, acc_lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  out_q;

    function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dword(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Request decode: signedness, magnitudes and the two divide special cases.
    logic            accept;
    logic            a_signed, b_signed;
    logic            sign_a_in, sign_b_in;
    logic [XLEN-1:0] abs_a_in, abs_b_in;
    logic            div_zero, div_ovf, special_in;
    logic [XLEN-1:0] special_val_in;

    assign accept    = in_valid & in_ready;
    assign a_signed  = (op_code == OP_MULH) || (op_code == OP_MULHSU) ||
                       (op_code == OP_DIV)  || (op_code == OP_REM);
    assign b_signed  = (op_code == OP_MULH) || (op_code == OP_DIV) || (op_code == OP_REM);
    assign sign_a_in = a_signed & in_a[XLEN-1];
    assign sign_b_in = b_signed & in_b[XLEN-1];
    assign abs_a_in  = neg_word(in_a, sign_a_in);
    assign abs_b_in  = neg_word(in_b, sign_b_in);

    assign div_zero   = op_code[2] && (in_b == '0);
    assign div_ovf    = ((op_code == OP_DIV) || (op_code == OP_REM)) &&
                        (in_a == INT_MIN) && (in_b == '1);
    assign special_in = div_zero | div_ovf;

    always_comb begin
        special_val_in = '0;
        if (div_zero)
            special_val_in = op_code[1] ? in_a : '1;
        else if (div_ovf)
            special_val_in = op_code[1] ? '0 : INT_MIN;
    end

    // Multiply step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole {hi,lo} pair right.
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_nxt, mul_lo_nxt;

    assign mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_hi_nxt = mul_sum[XLEN:1];
    assign mul_lo_nxt = {mul_sum[0], acc_lo_q[XLEN-1:1]};

    // Restoring divide step: hi holds the partial remainder, lo shifts the
    // dividend out at the top and the quotient bits in at the bottom.
    logic [XLEN:0]   div_shift, div_trial;
    logic            div_fits;
    logic [XLEN-1:0] div_hi_nxt, div_lo_nxt;

    assign div_shift  = {acc_hi_q, acc_lo_q[XLEN-1]};
    assign div_trial  = div_shift - {1'b0, mcand_q};
    assign div_fits   = ~div_trial[XLEN];
    assign div_hi_nxt = div_fits ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
    assign div_lo_nxt = {acc_lo_q[XLEN-2:0], div_fits};

    // Final sign correction and result selection.
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo_signed, rem_signed;
    logic [XLEN-1:0]   fix_result;

    assign prod_signed = neg_dword({acc_hi_q, acc_lo_q}, sign_a_q ^ sign_b_q);
    assign quo_signed  = neg_word(acc_lo_q, sign_a_q ^ sign_b_q);
    assign rem_signed  = neg_word(acc_hi_q, sign_a_q);

    always_comb begin
        fix_result = '0;
        if (special_q) begin
            fix_result = special_val_q;
        end else begin
            unique case (op_q)
                OP_MUL:                        fix_result = prod_signed[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_signed[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:               fix_result = quo_signed;
                OP_REM, OP_REMU:               fix_result = rem_signed;
                default:                       fix_result = '0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = special_in ? SPECIAL : CALC;
            CALC:    if (cnt_q == CNT_LAST) state_nxt = FIX;
            // Special results also pass through FIX so they appear two cycles after accept.
            SPECIAL: state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    assign out = out_q;

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q          <= '0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            mcand_q       <= '0;
            acc_hi_q      <= '0;
            acc_lo_q      <= '0;
            cnt_q         <= '0;
            out_q         <= '0;
        end else if (accept) begin
            op_q          <= op_code;
            sign_a_q      <= sign_a_in;
            sign_b_q      <= sign_b_in;
            special_q     <= special_in;
            special_val_q <= special_val_in;
            mcand_q       <= abs_b_in;
            acc_hi_q      <= '0;
            acc_lo_q      <= abs_a_in;
            cnt_q         <= '0;
        end else if (state == CALC) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (op_q[2]) begin
                acc_hi_q <= div_hi_nxt;
                acc_lo_q <= div_lo_nxt;
            end else begin
                acc_hi_q <= mul_hi_nxt;
                acc_lo_q <= mul_lo_nxt;
            end
        end else if (state == FIX) begin
            out_q <= fix_result;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of hand-computed results and latencies,
// plus sequences for asynchronous abort and output backpressure.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op_code;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_code   (op_code),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
        vecs.push_back(v);
    endtask

    // Issue one request with out_ready high; checks result, latency and release to idle.
    task automatic run_op(input vec_t v);
        int lat;
        @(negedge clk);
        check({v.name, " idle_ready"}, {31'b0, in_ready}, 32'd1);
        op_code  = v.op;
        in_a     = v.a;
        in_b     = v.b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        op_code  = 3'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1)
                check({v.name, " busy_not_ready"}, {31'b0, in_ready}, 32'd0);
        end
        check({v.name, " latency"}, lat, v.lat);
        check({v.name, " result"}, out, v.exp);
        @(posedge clk);
        #1;
        check({v.name, " consumed"}, {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int lat;
        int spurious;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        op_code   = 3'd0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        add(3'd0, 32'd7,        32'd6,        32'd42,       33, "MUL 7*6");
        add(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        33, "MUL -1*-1");
        add(3'd0, 32'd0,        32'h12345678, 32'd0,        33, "MUL 0*x");
        add(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, "MULH min*min");
        add(3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 33, "MULH max*max");
        add(3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 33, "MULH -3*5");
        add(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "MULHU");
        add(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "MULHSU");
        add(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "DIV -7/2");
        add(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "REM -7/2");
        add(3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, "DIV 7/-2");
        add(3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33, "REM 7/-2");
        add(3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33, "DIVU big");
        add(3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, "REMU big");
        add(3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, "DIVU x/1");
        add(3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 2,  "DIV 5/0");
        add(3'd7, 32'd5,        32'd0,        32'd5,        2,  "REMU 5/0");
        add(3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 2,  "REM -7/0");
        add(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  "DIV ovf");
        add(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2,  "REM ovf");
        add(3'd5, 32'd100,      32'd7,        32'd14,       33, "DIVU 100/7");
        add(3'd7, 32'd100,      32'd7,        32'd2,        33, "REMU 100/7");

        #12;
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset out", out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i]);

        // Abort a MUL mid-calculation with an asynchronous reset.
        @(negedge clk);
        op_code = 3'd0; in_a = 32'd3; in_b = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort out_valid", {31'b0, out_valid}, 32'd0);
        check("abort in_ready", {31'b0, in_ready}, 32'd1);
        check("abort out cleared", out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        spurious = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) spurious++;
        end
        check("abort no spurious valid", spurious, 0);
        check("abort idle ready", {31'b0, in_ready}, 32'd1);

        // Backpressure: result held while out_ready stays low; new requests ignored.
        out_ready = 1'b0;
        @(negedge clk);
        op_code = 3'd0; in_a = 32'd7; in_b = 32'd6; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp latency", lat, 33);
        check("bp result", out, 32'd42);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            op_code = 3'd5; in_a = 32'd100; in_b = 32'd7; in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp hold out", out, 32'd42);
            check("bp hold valid/ready", {30'b0, out_valid, in_ready}, 32'b10);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release", {30'b0, out_valid, in_ready}, 32'b01);
        check("bp out holds", out, 32'd42);
        run_op(vecs[20]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
